soc_wb_ext_responder: RTL

Wishbone B3 slave that terminates the tile-array external bus (`wb_ext_*`) of `mpsoc3d_or1k` in simulation and FPGA bring-up builds. It replaces the unconnected/`'x` tie-offs with a small word-addressed SRAM. It supports classic single cycles, registered-feedback incrementing bursts (linear, wrap4, wrap8, wrap16) and programmable wait states. Out-of-range accesses are reported on `wb_err_o`.

---
 rtl/soc_wb_ext_responder_if.sv | 41 ++++
 rtl/soc_wb_ext_responder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/soc_wb_ext_responder_if.sv
// Wishbone B3 bus bundle between the tile-array external port and its responder.
//
// Signals (named from the bus point of view, no direction affixes):
//   adr   byte address, bits [1:0] ignored by the responder
//   wdat  write data, master to slave
//   rdat  read data, slave to master, valid with ack
//   sel   byte lane enables, bit n covers byte [8n+7:8n]
//   we    1 = write
//   cyc   bus cycle active
//   stb   strobe
//   cab   legacy burst hint
//   cti   cycle type identifier
//   bte   burst type extension
//   ack   normal termination
//   err   error termination
//   rty   retry termination
interface soc_wb_ext_responder_if;
  logic [31:0] adr;
  logic [31:0] wdat;
  logic [31:0] rdat;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic        cab;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;
  logic        err;
  logic        rty;

  modport master (
    output adr, wdat, sel, we, cyc, stb, cab, cti, bte,
    input  rdat, ack, err, rty
  );

  modport slave (
    input  adr, wdat, sel, we, cyc, stb, cab, cti, bte,
    output rdat, ack, err, rty
  );
endinterface

// File: rtl/soc_wb_ext_responder.sv
// Wishbone B3 slave terminating the external tile-array bus with a small word-addressed SRAM.
// Supports classic cycles, registered-feedback incrementing bursts (linear, wrap4, wrap8,
// wrap16) and a fixed number of wait states before the first termination of every cycle.
// Accesses outside the window terminate with err.
//
// Parameters:
//   BASE_ADDR    byte base address of the window
//   MEM_WORDS    number of 32-bit words, power of two, >= 16
//   WAIT_STATES  extra cycles before the first ack of a cycle, 0..15
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset; memory contents survive it
//   wb   slave side of the Wishbone bundle
module soc_wb_ext_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned MEM_WORDS   = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input logic                   clk,
  input logic                   rst,
  soc_wb_ext_responder_if.slave wb
);

  localparam int unsigned AW       = $clog2(MEM_WORDS);
  localparam logic [32:0] WinStart = 33'(BASE_ADDR);
  localparam logic [32:0] WinEnd   = 33'(BASE_ADDR) + 33'(4 * MEM_WORDS);
  localparam logic [3:0]  WaitLoad = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {StIdle, StWait, StAck, StBurst} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   pred_q, pred_d;
  logic [31:0]     rdat_q;
  logic [31:0]     mem [MEM_WORDS];

  logic [32:0]     adr_word;
  logic [31:0]     offset;
  logic            hit;
  logic [AW-1:0]   widx;
  logic [AW-1:0]   nxt;
  logic            is_inc;
  logic            load_en;
  logic [AW-1:0]   load_idx;
  logic            ack;
  logic            err;
  logic            unused_bits;

  // Next word of a burst: wrap bursts only advance the low log2(N) index bits.
  function automatic logic [AW-1:0] next_idx(input logic [AW-1:0] idx, input logic [1:0] bte);
    logic [AW-1:0] inc;
    logic [AW-1:0] mask;
    inc = idx + AW'(1);
    case (bte)
      2'b01:   mask = AW'(3);
      2'b10:   mask = AW'(7);
      2'b11:   mask = AW'(15);
      default: mask = '1;
    endcase
    return (idx & ~mask) | (inc & mask);
  endfunction

  assign adr_word = {1'b0, wb.adr[31:2], 2'b00};
  assign hit      = (adr_word >= WinStart) && (adr_word < WinEnd);
  assign offset   = wb.adr - BASE_ADDR;
  assign widx     = offset[AW+1:2];
  assign nxt      = next_idx(widx, wb.bte);
  assign is_inc   = (wb.cti == 3'b010);

  assign unused_bits = ^{wb.cab, wb.adr[1:0], offset[1:0], offset[31:AW+2]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pred_d   = pred_q;
    load_en  = 1'b0;
    load_idx = widx;
    ack      = 1'b0;
    err      = 1'b0;

    if (!wb.cyc) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (wb.stb) begin
            if (WAIT_STATES == 0) begin
              state_d = StAck;
              load_en = 1'b1;
            end else begin
              state_d = StWait;
              cnt_d   = WaitLoad;
            end
          end
        end
        StWait: begin
          if (cnt_q == 4'd0) begin
            state_d = StAck;
            load_en = 1'b1;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        StAck: begin
          if (wb.stb) begin
            ack = hit;
            err = !hit;
            if (hit && is_inc) begin
              // Prefetch the predicted second beat so it can ack back-to-back.
              state_d  = StBurst;
              load_en  = 1'b1;
              load_idx = nxt;
              pred_d   = nxt;
            end else begin
              state_d = StIdle;
            end
          end
        end
        StBurst: begin
          if (wb.stb) begin
            if (!hit) begin
              err     = 1'b1;
              state_d = StIdle;
            end else if (widx != pred_q) begin
              // Master jumped: hold the beat one cycle and fetch the address it presented.
              load_en  = 1'b1;
              load_idx = widx;
              pred_d   = widx;
            end else begin
              ack = 1'b1;
              if (is_inc) begin
                load_en  = 1'b1;
                load_idx = nxt;
                pred_d   = nxt;
              end else begin
                state_d = StIdle;
              end
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (rst) begin
      ack = 1'b0;
      err = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      pred_q  <= '0;
      rdat_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pred_q  <= pred_d;
      if (load_en) begin
        rdat_q <= mem[load_idx];
      end
    end
  end

  // Memory has no reset so its contents survive rst; ack is already cleared during rst.
  always_ff @(posedge clk) begin
    if (ack && wb.we) begin
      for (int b = 0; b < 4; b++) begin
        if (wb.sel[b]) begin
          mem[widx][8*b +: 8] <= wb.wdat[8*b +: 8];
        end
      end
    end
  end

  assign wb.rdat = rdat_q;
  assign wb.ack  = ack;
  assign wb.err  = err;
  assign wb.rty  = 1'b0;

endmodule
